mux_scheduler: RTL

MUX_SCHEDULER -- requirements
Module: mux_scheduler

---
 rtl/mux_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mux_scheduler.sv
// Round-robin scheduler for a 4:1 shared channel. The grant slot lasts up to HOLD
// cycles, or ends early when the granted requester releases.
module mux_scheduler #(
    parameter int unsigned HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic [1:0] C,
    input  logic [1:0] D,
    output logic [1:0] S,
    output logic       EN,
    output logic [3:0] GNT,
    output logic [1:0] Y,
    output logic       SLOT_END
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic             en_q, en_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             slot_end_q, slot_end_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [1:0]       search_base;
    logic [2:0]       pick;
    logic             slot_done;

    // First set request after base, wrapping so that base itself is tried last.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        en_d        = en_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        slot_end_d  = 1'b0;
        search_base = (state_q == ST_GRANT) ? s_q : last_q;
        pick        = rr_pick(REQ, search_base);
        slot_done   = (cnt_q == '0) || !REQ[s_q];

        case (state_q)
            ST_IDLE: begin
                en_d = 1'b0;
                if (pick[2]) begin
                    state_d = ST_GRANT;
                    s_d     = pick[1:0];
                    en_d    = 1'b1;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_GRANT: begin
                if (slot_done) begin
                    last_d     = s_q;
                    slot_end_d = 1'b1;
                    if (pick[2]) begin
                        s_d   = pick[1:0];
                        cnt_d = CNT_RELOAD;
                    end else begin
                        // S keeps its last value while idle
                        state_d = ST_IDLE;
                        en_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase

        gnt_d = en_d ? (4'b0001 << s_d) : 4'b0000;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            s_q        <= 2'b00;
            en_q       <= 1'b0;
            gnt_q      <= 4'b0000;
            slot_end_q <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 2'b11;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            en_q       <= en_d;
            gnt_q      <= gnt_d;
            slot_end_q <= slot_end_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    // Shared channel data follows the registered select.
    always_comb begin
        Y = 2'b00;
        if (en_q) begin
            case (s_q)
                2'd0:    Y = A;
                2'd1:    Y = B;
                2'd2:    Y = C;
                default: Y = D;
            endcase
        end
    end

    assign S        = s_q;
    assign EN       = en_q;
    assign GNT      = gnt_q;
    assign SLOT_END = slot_end_q;

endmodule
